alu_rs: RTL and testbench

- Reservation station for the integer ALU, directly downstream of the instruction decoder.
- Accepts one decoded ALU op per cycle: opcode, two tagged operands and a destination ROB tag.
- Snoops the common data bus (CDB) to resolve pending operands.
- Issues one ready op per cycle to the ALU execute unit; supports a full flush on branch misprediction.

---
 rtl/alu_rs.sv | 196 +++++++++++++++++++
 tb/tb_alu_rs.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs
// Brief    : Integer ALU reservation station. Holds decoded ops, snoops the
//            CDB for missing operands, and issues one ready op per cycle.
// Revision : 1.0
// ============================================================================
module alu_rs #(
    parameter int                OP_W    = 5,
    parameter int                DATA_W  = 32,
    parameter int                LOCK_W  = 4,
    parameter logic [LOCK_W-1:0] NO_LOCK = 4'b1000,
    parameter int                ENTRIES = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      flush,
    input  logic                                      in_write,
    input  logic [OP_W+2*(LOCK_W+DATA_W)+LOCK_W-1:0]  in_bus,
    output logic                                      rs_stall,
    input  logic                                      cdb_valid,
    input  logic [LOCK_W-1:0]                         cdb_tag,
    input  logic [DATA_W-1:0]                         cdb_data,
    input  logic                                      alu_busy,
    output logic                                      ex_valid,
    output logic [OP_W-1:0]                           ex_op,
    output logic [DATA_W-1:0]                         ex_a,
    output logic [DATA_W-1:0]                         ex_b,
    output logic [LOCK_W-1:0]                         ex_dest
);

    localparam int c_idx_w = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int c_cnt_w = c_idx_w + 1;

    logic [OP_W-1:0]   w_in_op;
    logic [LOCK_W-1:0] w_in_lock1;
    logic [DATA_W-1:0] w_in_data1;
    logic [LOCK_W-1:0] w_in_lock2;
    logic [DATA_W-1:0] w_in_data2;
    logic [LOCK_W-1:0] w_in_dest;

    assign {w_in_op, w_in_lock1, w_in_data1, w_in_lock2, w_in_data2, w_in_dest} = in_bus;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [OP_W-1:0]    op_q    [ENTRIES];
    logic [OP_W-1:0]    op_d    [ENTRIES];
    logic [LOCK_W-1:0]  lock1_q [ENTRIES];
    logic [LOCK_W-1:0]  lock1_d [ENTRIES];
    logic [DATA_W-1:0]  data1_q [ENTRIES];
    logic [DATA_W-1:0]  data1_d [ENTRIES];
    logic [LOCK_W-1:0]  lock2_q [ENTRIES];
    logic [LOCK_W-1:0]  lock2_d [ENTRIES];
    logic [DATA_W-1:0]  data2_q [ENTRIES];
    logic [DATA_W-1:0]  data2_d [ENTRIES];
    logic [LOCK_W-1:0]  dest_q  [ENTRIES];
    logic [LOCK_W-1:0]  dest_d  [ENTRIES];

    logic              ex_valid_q, ex_valid_d;
    logic [OP_W-1:0]   ex_op_q,    ex_op_d;
    logic [DATA_W-1:0] ex_a_q,     ex_a_d;
    logic [DATA_W-1:0] ex_b_q,     ex_b_d;
    logic [LOCK_W-1:0] ex_dest_q,  ex_dest_d;

    logic [ENTRIES-1:0] w_ready;

    generate
        for (genvar g = 0; g < ENTRIES; g++) begin : g_ready
            assign w_ready[g] = valid_q[g] && (lock1_q[g] == NO_LOCK) && (lock2_q[g] == NO_LOCK);
        end
    endgenerate

    logic               w_issue;
    logic [c_idx_w-1:0] w_issue_idx;
    logic               w_free_found;
    logic [c_idx_w-1:0] w_free_idx;
    logic [c_cnt_w-1:0] w_free_cnt;

    // Descending scan so the last hit is the lowest index.
    always_comb begin
        w_issue      = 1'b0;
        w_issue_idx  = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_free_cnt   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_issue     = 1'b1;
                w_issue_idx = c_idx_w'(i);
            end
            if (!valid_q[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_idx_w'(i);
            end
            w_free_cnt = w_free_cnt + {{c_idx_w{1'b0}}, ~valid_q[i]};
        end
        if (alu_busy) begin
            w_issue = 1'b0;
        end
    end

    assign rs_stall = (w_free_cnt <= c_cnt_w'(1));

    logic w_byp1;
    logic w_byp2;

    assign w_byp1 = cdb_valid && (w_in_lock1 != NO_LOCK) && (w_in_lock1 == cdb_tag);
    assign w_byp2 = cdb_valid && (w_in_lock2 != NO_LOCK) && (w_in_lock2 == cdb_tag);

    always_comb begin
        valid_d    = valid_q;
        op_d       = op_q;
        lock1_d    = lock1_q;
        data1_d    = data1_q;
        lock2_d    = lock2_q;
        data2_d    = data2_q;
        dest_d     = dest_q;
        ex_valid_d = 1'b0;
        ex_op_d    = ex_op_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_dest_d  = ex_dest_q;

        if (flush) begin
            valid_d = '0;
        end else begin
            if (cdb_valid) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (valid_q[i] && (lock1_q[i] != NO_LOCK) && (lock1_q[i] == cdb_tag)) begin
                        lock1_d[i] = NO_LOCK;
                        data1_d[i] = cdb_data;
                    end
                    if (valid_q[i] && (lock2_q[i] != NO_LOCK) && (lock2_q[i] == cdb_tag)) begin
                        lock2_d[i] = NO_LOCK;
                        data2_d[i] = cdb_data;
                    end
                end
            end

            if (w_issue) begin
                ex_valid_d           = 1'b1;
                ex_op_d              = op_q[w_issue_idx];
                ex_a_d               = data1_q[w_issue_idx];
                ex_b_d               = data2_q[w_issue_idx];
                ex_dest_d            = dest_q[w_issue_idx];
                valid_d[w_issue_idx] = 1'b0;
            end

            // The free slot is chosen from registered state, so it never aliases the issued entry.
            if (in_write && w_free_found) begin
                valid_d[w_free_idx] = 1'b1;
                op_d[w_free_idx]    = w_in_op;
                dest_d[w_free_idx]  = w_in_dest;
                lock1_d[w_free_idx] = w_byp1 ? NO_LOCK  : w_in_lock1;
                data1_d[w_free_idx] = w_byp1 ? cdb_data : w_in_data1;
                lock2_d[w_free_idx] = w_byp2 ? NO_LOCK  : w_in_lock2;
                data2_d[w_free_idx] = w_byp2 ? cdb_data : w_in_data2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_dest_q  <= NO_LOCK;
        end else begin
            valid_q    <= valid_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_dest_q  <= ex_dest_d;
        end
    end

    // Payload is qualified by valid_q and needs no reset.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        lock1_q <= lock1_d;
        data1_q <= data1_d;
        lock2_q <= lock2_d;
        data2_q <= data2_d;
        dest_q  <= dest_d;
    end

    assign ex_valid = ex_valid_q;
    assign ex_op    = ex_op_q;
    assign ex_a     = ex_a_q;
    assign ex_b     = ex_b_q;
    assign ex_dest  = ex_dest_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rs
// Brief    : Self-checking bench for alu_rs: directed scenarios plus random
//            traffic compared against a behavioural station model.
// Revision : 1.0
// ============================================================================
module tb_alu_rs;

    localparam int         OP_W    = 5;
    localparam int         DATA_W  = 32;
    localparam int         LOCK_W  = 4;
    localparam int         ENTRIES = 4;
    localparam logic [3:0] NL      = 4'b1000;
    localparam int         IN_W    = OP_W + 2*(LOCK_W+DATA_W) + LOCK_W;

    logic              clk = 1'b0;
    logic              rst, flush, in_write, cdb_valid, alu_busy;
    logic [IN_W-1:0]   in_bus;
    logic [LOCK_W-1:0] cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              rs_stall, ex_valid;
    logic [OP_W-1:0]   ex_op;
    logic [DATA_W-1:0] ex_a, ex_b;
    logic [LOCK_W-1:0] ex_dest;

    int total = 0;
    int bad   = 0;

    alu_rs #(.OP_W(OP_W), .DATA_W(DATA_W), .LOCK_W(LOCK_W), .NO_LOCK(NL), .ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_write(in_write), .in_bus(in_bus),
        .rs_stall(rs_stall), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alu_busy(alu_busy), .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
        .ex_dest(ex_dest)
    );

    always #5 clk = ~clk;

    // Reference model: a slot table; issue and fill both take the lowest slot.
    bit                m_v  [ENTRIES];
    logic [OP_W-1:0]   m_op [ENTRIES];
    logic [LOCK_W-1:0] m_l1 [ENTRIES];
    logic [DATA_W-1:0] m_d1 [ENTRIES];
    logic [LOCK_W-1:0] m_l2 [ENTRIES];
    logic [DATA_W-1:0] m_d2 [ENTRIES];
    logic [LOCK_W-1:0] m_dst[ENTRIES];
    logic              m_ex_valid;
    logic [OP_W-1:0]   m_ex_op;
    logic [DATA_W-1:0] m_ex_a, m_ex_b;
    logic [LOCK_W-1:0] m_ex_dest;

    function automatic logic [IN_W-1:0] pack(input logic [OP_W-1:0] op, input logic [3:0] l1,
                                             input logic [31:0] d1, input logic [3:0] l2,
                                             input logic [31:0] d2, input logic [3:0] dst);
        return {op, l1, d1, l2, d2, dst};
    endfunction

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < ENTRIES; i++) if (!m_v[i]) n++;
        return n;
    endfunction

    task automatic model_update();
        int iss = -1;
        int fr  = -1;
        logic [OP_W-1:0] op; logic [3:0] l1, l2, dst; logic [31:0] d1, d2;
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) m_v[i] = 0;
            m_ex_valid = 0; m_ex_op = '0; m_ex_a = '0; m_ex_b = '0; m_ex_dest = NL;
            return;
        end
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) m_v[i] = 0;
            m_ex_valid = 0;
            return;
        end
        for (int i = 0; i < ENTRIES; i++) begin
            if (iss < 0 && !alu_busy && m_v[i] && m_l1[i] == NL && m_l2[i] == NL) iss = i;
            if (fr < 0 && !m_v[i]) fr = i;
        end
        if (cdb_valid) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (m_v[i] && m_l1[i] != NL && m_l1[i] == cdb_tag) begin m_l1[i] = NL; m_d1[i] = cdb_data; end
                if (m_v[i] && m_l2[i] != NL && m_l2[i] == cdb_tag) begin m_l2[i] = NL; m_d2[i] = cdb_data; end
            end
        end
        m_ex_valid = (iss >= 0);
        if (iss >= 0) begin
            m_ex_op = m_op[iss]; m_ex_a = m_d1[iss]; m_ex_b = m_d2[iss]; m_ex_dest = m_dst[iss];
            m_v[iss] = 0;
        end
        if (in_write) begin
            {op, l1, d1, l2, d2, dst} = in_bus;
            if (fr < 0) begin
                total++; bad++;
                $display("FAIL overflow_write got=dropped_write required=free_entry");
            end else begin
                if (cdb_valid && l1 != NL && l1 == cdb_tag) begin l1 = NL; d1 = cdb_data; end
                if (cdb_valid && l2 != NL && l2 == cdb_tag) begin l2 = NL; d2 = cdb_data; end
                m_v[fr] = 1; m_op[fr] = op; m_l1[fr] = l1; m_d1[fr] = d1;
                m_l2[fr] = l2; m_d2[fr] = d2; m_dst[fr] = dst;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; in_write = 0; cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic test_reset();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%0d required=0", ex_valid); end
        total++; if (ex_op !== 5'd0) begin bad++; $display("FAIL reset_ex_op got=%0d required=0", ex_op); end
        total++; if (ex_a !== 32'd0 || ex_b !== 32'd0) begin bad++; $display("FAIL reset_ex_ab got=%h/%h required=0/0", ex_a, ex_b); end
        total++; if (ex_dest !== NL) begin bad++; $display("FAIL reset_ex_dest got=%h required=%h", ex_dest, NL); end
        total++; if (rs_stall !== 1'b0) begin bad++; $display("FAIL reset_rs_stall got=%0d required=0", rs_stall); end
    endtask

    task automatic test_resolved();
        idle(); alu_busy = 0;
        in_write = 1; in_bus = pack(5'd1, NL, 32'd5, NL, 32'd7, 4'd2);
        step(); idle();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL resolved_no_early_issue got=%0d required=0", ex_valid); end
        step();
        total++; if (ex_valid !== 1'b1 || ex_op !== 5'd1 || ex_a !== 32'd5 || ex_b !== 32'd7 || ex_dest !== 4'd2) begin
            bad++; $display("FAIL resolved_issue got=v%0d op%0d a%0d b%0d d%0d required=v1 op1 a5 b7 d2", ex_valid, ex_op, ex_a, ex_b, ex_dest);
        end
        step();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL resolved_single_pulse got=%0d required=0", ex_valid); end
    endtask

    task automatic test_pending();
        idle(); alu_busy = 0;
        in_write = 1; in_bus = pack(5'd3, 4'd3, 32'd0, NL, 32'd9, 4'd5);
        step(); idle();
        step();
        cdb_valid = 1; cdb_tag = 4'd4; cdb_data = 32'h55;
        step(); idle();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL pending_wrong_tag got=%0d required=0", ex_valid); end
        cdb_valid = 1; cdb_tag = 4'd3; cdb_data = 32'h10;
        step(); idle();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL pending_cdb_same_edge got=%0d required=0", ex_valid); end
        step();
        total++; if (ex_valid !== 1'b1 || ex_a !== 32'h10 || ex_b !== 32'd9 || ex_dest !== 4'd5 || ex_op !== 5'd3) begin
            bad++; $display("FAIL pending_issue got=v%0d a%h b%h d%0d op%0d required=v1 a10 b9 d5 op3", ex_valid, ex_a, ex_b, ex_dest, ex_op);
        end
        step();
    endtask

    task automatic test_bypass();
        idle(); alu_busy = 0;
        in_write = 1; in_bus = pack(5'd7, NL, 32'h11, 4'd6, 32'h0, 4'd9);
        cdb_valid = 1; cdb_tag = 4'd6; cdb_data = 32'hAB;
        step(); idle();
        step();
        total++; if (ex_valid !== 1'b1 || ex_a !== 32'h11 || ex_b !== 32'hAB || ex_dest !== 4'd9) begin
            bad++; $display("FAIL bypass_issue got=v%0d a%h b%h d%0d required=v1 a11 bAB d9", ex_valid, ex_a, ex_b, ex_dest);
        end
        step();
    endtask

    task automatic test_fill_stall();
        logic [3:0] exp_stall [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] drop_stall[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        idle(); alu_busy = 1;
        for (int i = 0; i < 4; i++) begin
            in_write = 1; in_bus = pack(5'(i + 10), NL, 32'(100 + i), NL, 32'(200 + i), 4'(i));
            step();
            total++; if (rs_stall !== exp_stall[i][0]) begin bad++; $display("FAIL fill_stall_%0d got=%0d required=%0d", i, rs_stall, exp_stall[i][0]); end
        end
        idle(); alu_busy = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (ex_valid !== 1'b1 || ex_dest !== 4'(i) || ex_a !== 32'(100 + i) || ex_b !== 32'(200 + i)) begin
                bad++; $display("FAIL drain_order_%0d got=v%0d d%0d a%0d b%0d required=v1 d%0d", i, ex_valid, ex_dest, ex_a, ex_b, i);
            end
            total++; if (rs_stall !== drop_stall[i][0]) begin bad++; $display("FAIL drain_stall_%0d got=%0d required=%0d", i, rs_stall, drop_stall[i][0]); end
        end
        step();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0d required=0", ex_valid); end
    endtask

    task automatic test_flush();
        idle(); alu_busy = 0;
        in_write = 1; in_bus = pack(5'd2, 4'd3, 32'd0, NL, 32'd1, 4'd1);
        step();
        in_bus = pack(5'd2, NL, 32'd1, 4'd4, 32'd0, 4'd2);
        step();
        in_bus = pack(5'd2, NL, 32'd1, NL, 32'd2, 4'd3); flush = 1;
        step(); idle();
        for (int i = 0; i < 5; i++) begin
            cdb_valid = (i < 2); cdb_tag = (i == 0) ? 4'd3 : 4'd4; cdb_data = 32'hDEAD;
            step();
            total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_no_issue_%0d got=%0d required=0", i, ex_valid); end
        end
        total++; if (rs_stall !== 1'b0) begin bad++; $display("FAIL flush_empty_stall got=%0d required=0", rs_stall); end
    endtask

    task automatic test_reset_mid();
        idle(); alu_busy = 1;
        for (int i = 0; i < 4; i++) begin
            in_write = 1; in_bus = pack(5'd4, NL, 32'(i), NL, 32'(i), 4'(i));
            step();
        end
        idle(); rst = 1;
        step(); rst = 0; alu_busy = 0;
        total++; if (ex_valid !== 1'b0 || rs_stall !== 1'b0 || ex_dest !== NL) begin
            bad++; $display("FAIL reset_mid_state got=v%0d stall%0d d%h required=v0 stall0 d8", ex_valid, rs_stall, ex_dest);
        end
        step();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_no_pulse got=%0d required=0", ex_valid); end
        in_write = 1; in_bus = pack(5'd6, NL, 32'h77, NL, 32'h88, 4'd7);
        step(); idle();
        step();
        total++; if (ex_valid !== 1'b1 || ex_dest !== 4'd7 || ex_a !== 32'h77 || ex_b !== 32'h88) begin
            bad++; $display("FAIL reset_mid_reissue got=v%0d d%0d a%h b%h required=v1 d7 a77 b88", ex_valid, ex_dest, ex_a, ex_b);
        end
        step();
    endtask

    function automatic logic [3:0] rnd_lock();
        return ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 7)) : NL;
    endfunction

    task automatic test_random();
        int nf;
        idle();
        for (int c = 0; c < 800; c++) begin
            flush    = ($urandom_range(0, 59) == 0);
            alu_busy = ($urandom_range(0, 2) == 0);
            nf       = m_free();
            in_write = (nf >= 2) ? ($urandom_range(0, 1) == 1) : ((nf == 1) ? ($urandom_range(0, 3) == 0) : 1'b0);
            in_bus   = pack(5'($urandom), rnd_lock(), $urandom, rnd_lock(), $urandom, 4'($urandom));
            cdb_valid = ($urandom_range(0, 1) == 1);
            cdb_tag   = 4'($urandom_range(0, 7));
            cdb_data  = $urandom;
            step();
            total++; if (ex_valid !== m_ex_valid) begin bad++; $display("FAIL rand_ex_valid c=%0d got=%0d required=%0d", c, ex_valid, m_ex_valid); end
            total++; if (ex_op !== m_ex_op || ex_dest !== m_ex_dest) begin
                bad++; $display("FAIL rand_ex_op_dest c=%0d got=%0d/%0d required=%0d/%0d", c, ex_op, ex_dest, m_ex_op, m_ex_dest);
            end
            total++; if (ex_a !== m_ex_a || ex_b !== m_ex_b) begin
                bad++; $display("FAIL rand_ex_ab c=%0d got=%h/%h required=%h/%h", c, ex_a, ex_b, m_ex_a, m_ex_b);
            end
            total++; if (rs_stall !== (m_free() <= 1)) begin bad++; $display("FAIL rand_rs_stall c=%0d got=%0d required=%0d", c, rs_stall, m_free() <= 1); end
        end
        idle();
    endtask

    initial begin
        idle(); alu_busy = 0; in_bus = '0;
        rst = 1;
        step(); step();
        rst = 0;
        test_reset();
        test_resolved();
        test_pending();
        test_bypass();
        test_fill_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
